// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================
// vga_pkg : raster timing sets, FSM states and sync flag bundle.
// Rev 1.0
// ============================================================
package vga_pkg;

  // 640x480@60
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_H_POL    = 1'b0;
  localparam bit VGA_V_POL    = 1'b0;

  // 800x600@72
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 56;
  localparam int SVGA_H_SYNC   = 120;
  localparam int SVGA_H_BP     = 64;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 37;
  localparam int SVGA_V_SYNC   = 6;
  localparam int SVGA_V_BP     = 23;
  localparam bit SVGA_H_POL    = 1'b1;
  localparam bit SVGA_V_POL    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } vga_flags_t;

endpackage
`default_nettype wire

// File: rtl/vga_pix_div.sv
`default_nettype none
// ============================================================
// vga_pix_div : pixel-tick enable and DAC pixel clock from clk.
// Rev 1.0
// ============================================================
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en_o,
  output logic vga_clk
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] c_last = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] c_half = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] c_one  = DW'(1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_pix_div: CLK_DIV must be at least 2");
  end

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_en_q, pix_en_d;
  logic          vga_clk_q, vga_clk_d;

  // Outputs are registered from the next count so they align with div_cnt itself.
  always_comb begin
    div_cnt_d = (div_cnt_q == c_last) ? '0 : div_cnt_q + c_one;
    pix_en_d  = (div_cnt_d == c_last);
    vga_clk_d = (div_cnt_d >= c_half);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
      vga_clk_q <= vga_clk_d;
    end
  end

  assign pix_en_o = pix_en_q;
  assign vga_clk  = vga_clk_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================
// vga_timing_gen : programmable VGA raster timing generator.
//   Build option VGA_FRAME_CNT_EN adds a 16-bit frame counter.
// Rev 1.0
// ============================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = VGA_H_POL,
  parameter bit V_POL    = VGA_V_POL,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_DLY = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_i,
  output logic          pix_en_o,
  output logic          vga_clk,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          hsync,
  output logic          vsync,
  output logic          active_o,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic          line_start_o,
  output logic          frame_start_o,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0]   frame_cnt_o,
`endif
  output logic          busy_o
);

  localparam logic [XW-1:0] c_x_last     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] c_x_one      = XW'(1);
  localparam logic [XW-1:0] c_h_act_last = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] c_hs_first   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] c_hs_last    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] c_y_last     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] c_y_one      = YW'(1);
  localparam logic [YW-1:0] c_v_act_last = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] c_vs_first   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] c_vs_last    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..7");
  end

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk      (clk),
    .rst      (rst),
    .pix_en_o (pix_en_o),
    .vga_clk  (vga_clk)
  );

  vga_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_q, line_d;
  logic          frame_q, frame_d;
  vga_flags_t    flags_q, flags_d;
  vga_flags_t    out_flags;

  // line_q/frame_q mark the tick currently presented; the strobes fire on its pix_en clk.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    line_d  = line_q;
    frame_d = frame_q;
    if (pix_en_o) begin
      line_d  = 1'b0;
      frame_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (run_i) begin
            state_d = RUN;
            line_d  = 1'b1;
            frame_d = 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (state_q == DRAIN && !run_i && x_q == c_x_last && y_q == c_y_last) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
          end else begin
            state_d = run_i ? RUN : DRAIN;
            if (x_q == c_x_last) begin
              x_d     = '0;
              y_d     = (y_q == c_y_last) ? '0 : y_q + c_y_one;
              line_d  = 1'b1;
              frame_d = (y_q == c_y_last);
            end else begin
              x_d = x_q + c_x_one;
            end
          end
        end
        default: begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (pix_en_o) begin
      flags_d = '0;
      if (state_d != IDLE) begin
        flags_d.act = (x_d <= c_h_act_last) && (y_d <= c_v_act_last);
        flags_d.hs  = (x_d >= c_hs_first) && (x_d <= c_hs_last);
        flags_d.vs  = (y_d >= c_vs_first) && (y_d <= c_vs_last);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      flags_q <= flags_d;
    end
  end

  if (PIPE_DLY > 0) begin : g_pipe
    vga_flags_t dly_q [PIPE_DLY];
    vga_flags_t dly_d [PIPE_DLY];

    always_comb begin
      dly_d = dly_q;
      if (pix_en_o) begin
        dly_d[0] = flags_q;
        for (int i = 1; i < PIPE_DLY; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        dly_q <= dly_d;
      end
    end

    assign out_flags = dly_q[PIPE_DLY-1];
  end else begin : g_bypass
    assign out_flags = flags_q;
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign hsync         = out_flags.hs ? H_POL : ~H_POL;
  assign vsync         = out_flags.vs ? V_POL : ~V_POL;
  assign active_o      = out_flags.act;
  assign VGA_BLANK_N   = out_flags.act;
  assign VGA_SYNC_N    = 1'b1;
  assign line_start_o  = pix_en_o & line_q;
  assign frame_start_o = pix_en_o & frame_q;
  assign busy_o        = (state_q != IDLE);

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_o ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`else
  // Frame counter absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================
// tb_vga_timing_gen : randomized run/stop stimulus against a
//   frame-position reference model of the raster generator.
// Rev 1.0
// ============================================================
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam bit HP = 1'b1, VP = 1'b0;
  localparam int D  = 3;
  localparam int PD = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_i = 1'b0;
  logic pix_en_o, vga_clk, hsync, vsync, active_o, VGA_BLANK_N, VGA_SYNC_N;
  logic line_start_o, frame_start_o, busy_o;
  logic [XW-1:0] x_o;
  logic [YW-1:0] y_o;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .H_POL (HP), .V_POL (VP), .CLK_DIV (D), .PIPE_DLY (PD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run_i         (run_i),
    .pix_en_o      (pix_en_o),
    .vga_clk       (vga_clk),
    .x_o           (x_o),
    .y_o           (y_o),
    .hsync         (hsync),
    .vsync         (vsync),
    .active_o      (active_o),
    .VGA_BLANK_N   (VGA_BLANK_N),
    .VGA_SYNC_N    (VGA_SYNC_N),
    .line_start_o  (line_start_o),
    .frame_start_o (frame_start_o),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt_o   (frame_cnt_o),
`endif
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: frame position p = y*HT + x while running; flags history for the sync lag.
  int         n_edge, p, m_fc;
  bit         m_on, m_drain;
  logic [2:0] hist[$];

  int clk_abs = 0, fs_seen = 0, fs_prev = 0, fs_last = 0;
  int act_cnt = 0, act_prev = 0, act_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] flags(input int pos, input bit on);
    int x, y;
    if (!on) return 3'b000;
    x = pos % HT;
    y = pos / HT;
    return {(x >= HA + HF) && (x < HA + HF + HS),
            (y >= VA + VF) && (y < VA + VF + VS),
            (x < HA) && (y < VA)};
  endfunction

  task automatic model_reset();
    n_edge = 0; p = 0; m_fc = 0; m_on = 1'b0; m_drain = 1'b0;
    hist.delete();
    for (int i = 0; i <= PD; i++) hist.push_back(3'b000);
  endtask

  task automatic model_tick(input bit r);
    if (m_on && p == 0) m_fc = (m_fc + 1) % 65536;
    if (!m_on) begin
      if (r) begin m_on = 1'b1; p = 0; m_drain = 1'b0; end
    end else if (p == FT - 1 && m_drain && !r) begin
      m_on = 1'b0; p = 0;
    end else begin
      p = (p + 1) % FT;
      m_drain = !r;
    end
    hist.push_front(flags(p, m_on));
    void'(hist.pop_back());
  endtask

  task automatic compare();
    int ph;
    bit pe;
    logic [2:0] e;
    ph = n_edge % D;
    pe = (ph == D - 1);
    e  = hist[PD];
    chk("pix_en", pix_en_o, pe);
    chk("vga_clk", vga_clk, ph >= D / 2);
    chk("x", x_o, m_on ? p % HT : 0);
    chk("y", y_o, m_on ? p / HT : 0);
    chk("hsync", hsync, e[2] ? HP : !HP);
    chk("vsync", vsync, e[1] ? VP : !VP);
    chk("active", active_o, e[0]);
    chk("blank_n", VGA_BLANK_N, e[0]);
    chk("sync_n", VGA_SYNC_N, 1'b1);
    chk("line_start", line_start_o, pe && m_on && (p % HT == 0));
    chk("frame_start", frame_start_o, pe && m_on && (p == 0));
    chk("busy", busy_o, m_on);
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt_o, m_fc);
`endif
    if (pix_en_o === 1'b1 && active_o === 1'b1) act_cnt++;
    if (frame_start_o === 1'b1) begin
      fs_seen++;
      fs_prev = fs_last;  fs_last = clk_abs;
      act_prev = act_last; act_last = act_cnt;
    end
  endtask

  task automatic cyc();
    bit r;
    @(posedge clk);
    r = run_i;
    n_edge++;
    clk_abs++;
    if (n_edge % D == 0) model_tick(r);
    #1;
    compare();
  endtask

  task automatic wait_pos(input int target, input int budget);
    int k;
    k = 0;
    while (!(m_on && p == target) && k < budget) begin cyc(); k++; end
    chk("wait_pos_reached", m_on && p == target, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (m_on && k < budget) begin cyc(); k++; end
    chk("wait_idle_reached", m_on, 1'b0);
  endtask

  task automatic wait_fs(input int budget);
    int k, s;
    k = 0;
    s = fs_seen;
    while (fs_seen == s && k < budget) begin cyc(); k++; end
    chk("wait_frame_start", fs_seen != s, 1'b1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_period_clks"}, fs_last - fs_prev, FT * D);
    chk({tag, "_active_ticks"}, act_last - act_prev, HA * VA);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    #10 compare();
    @(negedge clk) rst = 1'b1;

    // idle with run low: nothing moves except the divider
    repeat (8 * D) cyc();

    // continuous run: two complete frames
    run_i = 1'b1;
    wait_fs(4 * FT * D);
    wait_fs(4 * FT * D);
    wait_fs(4 * FT * D);
    check_frame("run");

    // stop mid-frame: drains to frame end then idles
    wait_pos(3 * HT + $urandom_range(0, HT - 1), 4 * FT * D);
    run_i = 1'b0;
    wait_idle(4 * FT * D);
    chk("stop_x", x_o, 0);
    chk("stop_busy", busy_o, 1'b0);
    repeat (3 * HT * D) cyc();

    // drop and reassert within one frame: frame is not interrupted
    run_i = 1'b1;
    wait_fs(4 * FT * D);
    wait_pos(2 * HT + $urandom_range(0, HT - 1), 4 * FT * D);
    run_i = 1'b0;
    wait_pos(4 * HT + $urandom_range(0, HT - 1), 4 * FT * D);
    run_i = 1'b1;
    wait_fs(4 * FT * D);
    check_frame("drain_resume");

    // random run/stop with occasional sub-tick glitches
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run_i = ~run_i;
      cyc();
      if ($urandom_range(0, 99) == 0) begin
        run_i = ~run_i;
        cyc();
        run_i = ~run_i;
      end
    end

    // asynchronous reset mid-frame
    run_i = 1'b1;
    wait_pos(4 * HT + 10, 4 * FT * D);
    #2 rst = 1'b0;
    model_reset();
    #1 compare();
    repeat (2) @(posedge clk);
    #1 compare();
    @(negedge clk) rst = 1'b1;
    wait_fs(4 * FT * D);
    wait_fs(4 * FT * D);
    repeat (20) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
